hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It is the producer of the control-select, bubble and stall signals that the ID-stage control mux, PC, IF/ID, ID/EX and EX/MEM registers consume.
- Detects load-use hazards and resolves taken branches (resolved in MEM) by flushing.
- Freezes the whole pipeline while data memory is busy.
- Keeps saturating stall/flush statistics and a memory-wait watchdog.

Parameters:
CNT_W, 16, width of stall_cnt_o / flush_cnt_o (saturating)
MAX_WAIT, 64, consecutive dmem_busy_i cycles before timeout_o asserts
WAIT_W, 8, width of internal wait counter (must hold MAX_WAIT)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
idex_memread_i  in  1  ID/EX instruction is a load
idex_rt_i  in  5  ID/EX load destination register
ifid_rs_i  in  5  IF/ID source register rs
ifid_rt_i  in  5  IF/ID source register rt
ifid_use_rt_i  in  1  IF/ID instruction reads rt
branch_taken_i  in  1  EX/MEM branch resolved taken
dmem_busy_i  in  1  data memory not ready this cycle
pc_write_o  out  1  PC write enable
ifid_write_o  out  1  IF/ID write enable
ctrl_sel_o  out  1  1 = pass control, 0 = insert bubble into ID/EX
ifid_flush_o  out  1  clear IF/ID
idex_flush_o  out  1  clear ID/EX
exmem_flush_o  out  1  clear EX/MEM
pipe_hold_o  out  1  hold ID/EX, EX/MEM, MEM/WB
timeout_o  out  1  sticky memory-wait timeout
stall_cnt_o  out  CNT_W  load-use bubbles inserted
flush_cnt_o  out  CNT_W  branch flushes performed
state_o  out  2  0 = RUN, 1 = FREEZE

Behaviour:
- Registered state: FSM {RUN, FREEZE}, flush_pend, wait_cnt, timeout_o, both counters. Other outputs are combinational (Mealy) from state plus inputs.
- While rst_i = 0: state RUN, flush_pend 0, wait_cnt 0, counters 0, timeout_o 0.
- Also while rst_i = 0: pc_write_o 0, ifid_write_o 0, ctrl_sel_o 0, all flushes 0, pipe_hold_o 1.
- Priority each cycle: dmem_busy_i > flush (branch_taken_i | flush_pend) > load-use > normal.
- Busy (dmem_busy_i = 1):
  - Next state FREEZE.
  - pc_write_o 0, ifid_write_o 0, ctrl_sel_o 1, flushes 0, pipe_hold_o 1.
  - branch_taken_i = 1 sets flush_pend.
  - wait_cnt increments and saturates at MAX_WAIT.
  - timeout_o sets on the cycle wait_cnt reaches MAX_WAIT and stays set until reset.
- Not busy: next state RUN, wait_cnt cleared, pipe_hold_o 0. Rules below apply in the same cycle, including the first cycle after FREEZE.
- Flush (branch_taken_i | flush_pend):
  - ifid_flush_o, idex_flush_o, exmem_flush_o = 1 for exactly one cycle.
  - ctrl_sel_o 0, pc_write_o 1 (PC loads branch target), ifid_write_o 1.
  - Load-use detection is suppressed this cycle.
  - flush_pend cleared; flush_cnt_o += 1 (saturating).
- Load-use hazard, defined as idex_memread_i & idex_rt_i != 0 & (idex_rt_i == ifid_rs_i | (ifid_use_rt_i & idex_rt_i == ifid_rt_i)):
  - pc_write_o 0, ifid_write_o 0, ctrl_sel_o 0.
  - stall_cnt_o += 1 (saturating).
  - Exactly one bubble per load: the next cycle ID/EX carries the bubble, so idex_memread_i = 0.
- Normal: pc_write_o 1, ifid_write_o 1, ctrl_sel_o 1, flushes 0.
- Register $zero (rt = 0) never causes a stall.
- Counters saturate at 2^CNT_W − 1 and never wrap.
- Reset asserted mid-FREEZE or with flush_pend set: all state clears, and the pending flush is discarded.

Decomposition:
- Shared package (cpu_pkg): state encoding localparams ST_RUN = 2'd0, ST_FREEZE = 2'd1; REG_ZERO = 5'd0; register-index width 5.
- One natural sub-module: sat_counter (parameterised width, enable, async active-low clear), instantiated twice for stall_cnt_o and flush_cnt_o.
- Hazard compare and FSM stay in the top module.

Test Plan:
1. Reset release, no hazards, 10 cycles -> pc_write_o = ifid_write_o = ctrl_sel_o = 1, flushes 0, counters 0, state_o 0.
2. idex_memread_i = 1, idex_rt_i = 8, ifid_rs_i = 8 for one cycle -> same cycle pc_write_o 0, ifid_write_o 0, ctrl_sel_o 0; stall_cnt_o = 1 next edge. Repeat with idex_rt_i = 0 -> no stall.
3. branch_taken_i = 1 with a simultaneous load-use match -> all three flushes 1, ctrl_sel_o 0, pc_write_o 1, stall_cnt_o unchanged, flush_cnt_o = 1.
4. dmem_busy_i = 1 for 3 cycles with branch_taken_i = 1 in the 2nd -> pipe_hold_o 1, state_o 1, no flush during busy. First non-busy cycle: flushes 1, flush_cnt_o = 1, flush_pend cleared.
5. dmem_busy_i held for MAX_WAIT = 64 cycles -> timeout_o rises after the 64th busy cycle and stays 1 after busy drops, until rst_i is pulsed low.
6. CNT_W = 2, 5 load-use stalls -> stall_cnt_o reads 1, 2, 3, 3, 3. Then assert rst_i low asynchronously mid-FREEZE -> outputs take reset values immediately, counters 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core's hazard control: register index
// width, the $zero index and the hazard controller's state encoding.
package cpu_pkg;

  localparam int REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FREEZE = 2'd1;

  typedef enum logic [1:0] {
    S_RUN    = ST_RUN,
    S_FREEZE = ST_FREEZE
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: increment when enabled unless already at the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes (branches
// resolve in MEM), whole-pipe freeze while data memory is busy, plus
// saturating stall/flush statistics and a sticky memory-wait watchdog.
// A branch seen during a freeze is remembered in flush_pend and performed
// on the first non-busy cycle.
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64,
  parameter int WAIT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_use_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ctrl_sel_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             pipe_hold_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_o
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  hz_state_e         state_q, state_d;
  logic              flush_pend_q, flush_pend_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              load_use;
  logic              do_flush;
  logic              stall_en;
  logic              flush_en;

  // $zero is never a real dependency, so it never stalls
  assign load_use = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                    ((idex_rt_i == ifid_rs_i) ||
                     (ifid_use_rt_i && (idex_rt_i == ifid_rt_i)));

  assign do_flush = branch_taken_i || flush_pend_q;

  // Next state and Mealy outputs; priority busy > flush > load-use > normal
  always_comb begin
    state_d       = state_q;
    flush_pend_d  = flush_pend_q;
    wait_d        = wait_q;
    timeout_d     = timeout_q;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ctrl_sel_o    = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    pipe_hold_o   = 1'b1;
    stall_en      = 1'b0;
    flush_en      = 1'b0;
    if (!rst_i) begin
      // reset: everything held, defaults above already describe it
    end else if (dmem_busy_i) begin
      state_d    = S_FREEZE;
      ctrl_sel_o = 1'b1;
      if (branch_taken_i) begin
        flush_pend_d = 1'b1;
      end
      if (wait_q != WAIT_MAX) begin
        wait_d = wait_q + WAIT_W'(1);
      end
      if (wait_d == WAIT_MAX) begin
        timeout_d = 1'b1;
      end
    end else begin
      state_d     = S_RUN;
      wait_d      = '0;
      pipe_hold_o = 1'b0;
      if (do_flush) begin
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        flush_pend_d  = 1'b0;
        flush_en      = 1'b1;
      end else if (load_use) begin
        stall_en = 1'b1;
      end else begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ctrl_sel_o   = 1'b1;
      end
    end
  end

  // State registers; reset discards any pending flush
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_RUN;
      flush_pend_q <= 1'b0;
      wait_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      wait_q       <= wait_d;
      timeout_q    <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (stall_en),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (flush_en),
    .cnt_o  (flush_cnt_o)
  );

  assign timeout_o = timeout_q;
  assign state_o   = state_q;

endmodule
